// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: width codes, FSM states,
// the latched request record and the alignment legality rule.
package lsu_pkg;
  localparam int NUM_LANES       = 4;
  localparam int VEC_W           = 8;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    LSU_BYTE    = 2'b00,
    LSU_HALF    = 2'b01,
    LSU_WORD    = 2'b10,
    LSU_ILLEGAL = 2'b11
  } lsuWidth_e;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    RESPOND
  } lsuState_e;

  // Only the fields still needed after the bus registers are loaded.
  typedef struct packed {
    lsuWidth_e  width;
    logic [1:0] byteOffset;
    logic       signExtend;
  } lsuReq_t;

  function automatic logic isLegal(input lsuWidth_e width, input logic [1:0] offset);
    case (width)
      LSU_BYTE: return 1'b1;
      LSU_HALF: return ~offset[0];
      LSU_WORD: return offset == 2'b00;
      default:  return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store replication, byte-enable pattern and
// load extraction with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  lsuWidth_e                           width,
  input  logic [1:0]                          byteOffset,
  input  logic                                signExtend,
  input  logic [31:0]                         storeData,
  input  logic [31:0]                         readWord,
  output logic [NUM_LANES-1:0][VEC_W-1:0]     laneData,
  output logic [NUM_LANES-1:0]                byteEnable,
  output logic [31:0]                         loadData
);
  logic [NUM_LANES-1:0] sizeMask;
  logic [31:0]          shifted;

  always_comb begin
    sizeMask = 4'b1111;
    case (width)
      LSU_BYTE: sizeMask = 4'b0001;
      LSU_HALF: sizeMask = 4'b0011;
      default:  sizeMask = 4'b1111;
    endcase
  end

  assign byteEnable = sizeMask << byteOffset;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign laneData[i] = (width == LSU_BYTE) ? storeData[7:0] :
                         (width == LSU_HALF) ? storeData[VEC_W*(i%2) +: VEC_W] :
                                               storeData[VEC_W*i +: VEC_W];
  end

  assign shifted = readWord >> {byteOffset, 3'b000};

  always_comb begin
    loadData = shifted;
    case (width)
      LSU_BYTE: loadData = {{24{signExtend & shifted[7]}},  shifted[7:0]};
      LSU_HALF: loadData = {{16{signExtend & shifted[15]}}, shifted[15:0]};
      default:  loadData = shifted;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store unit: request latch, legality check, bus handshake
// with timeout and a single-cycle response back to the core.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        CoreClock,
  input  logic        CoreReset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [31:0] ReqAddress,
  input  logic [1:0]  ReqWidth,
  input  logic        ReqSignExtend,
  input  logic [31:0] ReqWriteData,
  output logic        RespValid,
  output logic        RespError,
  output logic [31:0] RespReadData,
  output logic [31:0] AddressBus,
  output logic [31:0] DataWriteBus,
  output logic [3:0]  ByteEnable,
  output logic        ReadAssert,
  output logic        WriteAssert,
  input  logic [31:0] DataReadBus,
  input  logic        ReadOK,
  input  logic        WriteOK
);
  lsuState_e state;
  lsuReq_t   req;
  logic [7:0] waitCount;

  lsuWidth_e  alignWidth;
  logic [1:0] alignOffset;
  logic       alignSign;
  logic [NUM_LANES-1:0][VEC_W-1:0] alignData;
  logic [NUM_LANES-1:0]            alignBe;
  logic [31:0]                     alignLoad;
  logic okSeen;
  logic timeoutHit;

  assign ReqReady = (state == IDLE);

  // One aligner serves both phases: live request fields at accept, latched ones afterwards.
  assign alignWidth  = (state == IDLE) ? lsuWidth_e'(ReqWidth) : req.width;
  assign alignOffset = (state == IDLE) ? ReqAddress[1:0]       : req.byteOffset;
  assign alignSign   = (state == IDLE) ? ReqSignExtend         : req.signExtend;

  lsu_lane_align u_align (
    .width      (alignWidth),
    .byteOffset (alignOffset),
    .signExtend (alignSign),
    .storeData  (ReqWriteData),
    .readWord   (DataReadBus),
    .laneData   (alignData),
    .byteEnable (alignBe),
    .loadData   (alignLoad)
  );

  // Only the OK matching the current wait state counts; the other one is ignored.
  assign okSeen     = (state == READ_WAIT) ? ReadOK : (state == WRITE_WAIT) ? WriteOK : 1'b0;
  assign timeoutHit = (waitCount == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CoreClock or posedge CoreReset) begin
    if (CoreReset) begin
      state        <= IDLE;
      req          <= '0;
      waitCount    <= '0;
      AddressBus   <= '0;
      DataWriteBus <= '0;
      ByteEnable   <= '0;
      ReadAssert   <= 1'b0;
      WriteAssert  <= 1'b0;
      RespValid    <= 1'b0;
      RespError    <= 1'b0;
      RespReadData <= '0;
    end else begin
      RespValid <= 1'b0;
      case (state)
        IDLE: begin
          if (ReqValid) begin
            req       <= '{width: lsuWidth_e'(ReqWidth), byteOffset: ReqAddress[1:0],
                           signExtend: ReqSignExtend};
            waitCount <= '0;
            if (!isLegal(lsuWidth_e'(ReqWidth), ReqAddress[1:0])) begin
              state        <= RESPOND;
              RespValid    <= 1'b1;
              RespError    <= 1'b1;
              RespReadData <= '0;
            end else begin
              AddressBus   <= {2'b00, ReqAddress[31:2]};
              ByteEnable   <= alignBe;
              DataWriteBus <= alignData;
              ReadAssert   <= ~ReqWrite;
              WriteAssert  <= ReqWrite;
              state        <= ReqWrite ? WRITE_WAIT : READ_WAIT;
            end
          end
        end
        READ_WAIT, WRITE_WAIT: begin
          if (okSeen || timeoutHit) begin
            ReadAssert   <= 1'b0;
            WriteAssert  <= 1'b0;
            RespValid    <= 1'b1;
            RespError    <= ~okSeen;
            RespReadData <= (okSeen && state == READ_WAIT) ? alignLoad : '0;
            state        <= RESPOND;
          end else begin
            waitCount <= waitCount + 8'd1;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
